id_stage: RTL and testbench
===========================

# id_stage

Decode stage of the five-stage LC-3b pipeline, directly upstream of the ID/EX register. Holds the 8×16 register file and the NZP condition-code register, decodes the IF/ID instruction into a `ctrl_struct`, and reads operands with write-back bypass. A load scoreboard (per-register in-flight load counters) produces the load-use interlock: it stalls IF/ID and injects a bubble into ID/EX.

## Interface
- No parameters; widths fixed (16-bit datapath, 8 registers, 2-bit counters).
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `if_id_valid` in 1: IF/ID holds a real instruction.
- `if_id_pc`, `if_id_ir` in 16: PC+2 and instruction from IF/ID.
- `flush` in 1: taken branch/jump; the IF/ID instruction is squashed.
- `mem_stall` in 1: downstream memory stall; freezes the whole front end.
- `wb_regfile_we` in 1, `wb_dest` in 3, `wb_data` in 16: write-back port.
- `wb_cc_we` in 1: write-back sets NZP from `wb_data`.
- `wb_is_load` in 1: the write-back instruction is LDR/LDB/LDI.
- `pc_out`, `ir_out`, `reg_a_out`, `reg_b_out` out 16: feed the ID/EX `pc_in`/`ir_in`/`reg_a_in`/`reg_b_in`.
- `cc_out` out 3: current NZP with bypass.
- `ctrl_out` out 30: decoded `ctrl_struct`, fields per `lc3b_types`.
- `id_ex_load`, `id_ex_clear` out 1: ID/EX register controls.
- `if_id_load` out 1: IF/ID and PC advance enable.

## Operation
- Source fields:
  - sr1 = ir[8:6] for ADD, AND, NOT, LDR, LDB, LDI, STR, STB, STI, JMP, JSRR (JSR with ir[11]=0), SHF.
  - sr2 = ir[2:0] for ADD/AND with ir[5]=0.
  - sr2 = ir[11:9] for STR/STB/STI (store data).
  - BR uses CC.
- Destination: ir[11:9] for ADD, AND, NOT, LEA, SHF, LDR, LDB, LDI; R7 for JSR, JSRR, TRAP.
- Register file:
  - Write on the clk edge when `wb_regfile_we`.
  - Reads are write-through: if `wb_regfile_we` and `wb_dest` equals the read index, the read returns `wb_data`.
- CC:
  - When `wb_cc_we`, NZP = {wb_data[15], wb_data==0, !wb_data[15] && wb_data!=0}.
  - `cc_out` bypasses the value being written in the same cycle.
- Scoreboard:
  - `cnt[r]` (2 bits) counts issued-but-unretired loads targeting r; `cc_cnt` (2 bits) counts all in-flight loads.
  - Issue = if_id_valid && !stall && !flush && !mem_stall.
  - On issue of a load: `cnt[dest]` and `cc_cnt` increment.
  - When `wb_is_load && wb_regfile_we`: `cnt[wb_dest]` and `cc_cnt` decrement.
  - Simultaneous increment and decrement of the same counter leaves it unchanged.
  - Counts never exceed 3 (EX, MEM, WB depth). Increment at 3 or decrement at 0 is illegal; the bench asserts it never happens.
- Hazard (`stall`):
  - Raised when if_id_valid and a used source r has cnt[r]!=0, except when cnt[r]==1, wb_is_load, wb_regfile_we and wb_dest==r (value arrives via write-through).
  - BR with cc_cnt!=0 stalls, except when cc_cnt==1 and wb_is_load && wb_cc_we.
- Pipeline controls:
  - `if_id_load` = !mem_stall && !stall.
  - `id_ex_load` = !mem_stall.
  - `id_ex_clear` = !mem_stall && (stall || flush || !if_id_valid).
  - `stall` ORed with `flush` results in a bubble only; a flushed instruction never touches the scoreboard.
- Datapath outputs: `pc_out`/`ir_out` pass the IF/ID values; `ctrl_out` is the decode of ir[15:12] (all-zero when !if_id_valid).

## Timing
- Decode, register read, hazard and control outputs are combinational from IF/ID and WB inputs within the cycle.
- Register, CC and counter updates occur on the rising edge.
- Load-use distance 1 (load in EX, consumer in ID): 2 bubble cycles. The consumer issues in the cycle the load is in WB.
- Distance 2: 1 bubble. Distance 3: 0 bubbles via write-through.
- `mem_stall` high: no scoreboard or register-file change from issue. WB writes still commit only if the WB stage asserts them.
- Reset (asynchronous, at any point including mid-stall):
  - All registers 0x0000.
  - NZP = 3'b010.
  - All counters 0.
  - Outputs settle to: `if_id_load`=1, `id_ex_load`=1, `id_ex_clear`=1 (IF/ID invalid after reset), `ctrl_out`=0.

## Test plan
- Reset, then WB writes R3=0x1234. Next-cycle ADD R1,R3,R2 -> `reg_a_out`=0x1234. Same-cycle write to R3 with a read of R3 -> 0x1234 via bypass.
- LDR R2 issued, followed immediately by ADD R4,R2,R2 -> two cycles of `if_id_load`=0 and `id_ex_clear`=1. The ADD issues in the load's WB cycle with `reg_a_out`=`reg_b_out`=`wb_data`.
- LDR R2; unrelated NOT R5; ADD R4,R2,R0 -> exactly 1 bubble. With two unrelated instructions between -> 0 bubbles.
- Two back-to-back loads to R2 -> cnt[R2] reaches 2. After the first WB, a consumer still stalls until the second WB.
- Load in EX, BRz in ID -> stall until the load WB sets NZP. With `wb_data`=0, `cc_out`=3'b010 in the issue cycle.
- `mem_stall` held 3 cycles during an interlock -> no counter change and outputs frozen. Assert `reset` mid-stall -> counters 0, `if_id_load`=1, `id_ex_clear`=1, NZP=3'b010.

Source files
------------

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID, write-back and ID/EX-facing signals of the LC-3b decode stage.
//   slave  : the decode stage (id_stage)
//   master : the surrounding pipeline (IF/ID register, WB stage, ID/EX register)
interface id_stage_if;
    logic        if_id_valid;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_ir;
    logic        flush;
    logic        mem_stall;
    logic        wb_regfile_we;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_cc_we;
    logic        wb_is_load;
    logic [15:0] pc_out;
    logic [15:0] ir_out;
    logic [15:0] reg_a_out;
    logic [15:0] reg_b_out;
    logic [2:0]  cc_out;
    logic [29:0] ctrl_out;
    logic        id_ex_load;
    logic        id_ex_clear;
    logic        if_id_load;

    modport slave (
        input  if_id_valid, if_id_pc, if_id_ir, flush, mem_stall,
               wb_regfile_we, wb_dest, wb_data, wb_cc_we, wb_is_load,
        output pc_out, ir_out, reg_a_out, reg_b_out, cc_out, ctrl_out,
               id_ex_load, id_ex_clear, if_id_load
    );

    modport master (
        output if_id_valid, if_id_pc, if_id_ir, flush, mem_stall,
               wb_regfile_we, wb_dest, wb_data, wb_cc_we, wb_is_load,
        input  pc_out, ir_out, reg_a_out, reg_b_out, cc_out, ctrl_out,
               id_ex_load, id_ex_clear, if_id_load
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: LC-3b decode stage -- register file, NZP register, decode,
// write-through operand read and load-use interlock via a load scoreboard.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-high, clears registers, counters, NZP=010
//   bus   : id_stage_if.slave -- IF/ID inputs, flush/mem_stall, WB port,
//           ID/EX operand/control outputs and pipeline load/clear controls
// ctrl_out layout (msb..lsb): opcode[4] aluop[3] load_regfile load_cc
//   mem_read mem_write mem_byte indirect is_br is_jmp is_jsr is_trap use_imm
//   dest[3] sr1[3] sr2[3] sr1_used sr2_used cc_used
module id_stage (
    input  logic       clk,
    input  logic       reset,
    id_stage_if.slave  bus
);
    localparam int BR = 0, ADD = 1, LDB = 2, STB = 3, JSR = 4, AND = 5, LDR = 6, STR = 7;
    localparam int NOT = 9, LDI = 10, STI = 11, JMP = 12, SHF = 13, LEA = 14, TRAP = 15;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] aluop;
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       indirect;
        logic       is_br;
        logic       is_jmp;
        logic       is_jsr;
        logic       is_trap;
        logic       use_imm;
        logic [2:0] dest;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       sr1_used;
        logic       sr2_used;
        logic       cc_used;
    } ctrl_t;

    logic [15:0] rf [8];
    logic [1:0]  cnt [8];
    logic [1:0]  cc_cnt;
    logic [2:0]  cc;
    logic [15:0] ir, oh;
    logic [2:0]  sr1, sr2, dest, wb_nzp;
    logic        is_st, is_load, writes, sr1_used, sr2_used;
    logic        haz_a, haz_b, haz_cc, stall, inc_ld, dec_ld;
    ctrl_t       ctrl;

    assign ir       = bus.if_id_ir;
    assign oh       = 16'd1 << ir[15:12];
    assign is_st    = oh[STR] | oh[STB] | oh[STI];
    assign is_load  = oh[LDR] | oh[LDB] | oh[LDI];
    assign writes   = oh[ADD] | oh[AND] | oh[NOT] | oh[LEA] | oh[SHF] | is_load | oh[JSR] | oh[TRAP];
    assign sr1      = ir[8:6];
    assign sr2      = is_st ? ir[11:9] : ir[2:0];
    assign dest     = (oh[JSR] | oh[TRAP]) ? 3'd7 : ir[11:9];
    assign sr1_used = oh[ADD] | oh[AND] | oh[NOT] | is_load | is_st | oh[JMP] | (oh[JSR] & ~ir[11]) | oh[SHF];
    assign sr2_used = ((oh[ADD] | oh[AND]) & ~ir[5]) | is_st;

    always_comb begin
        ctrl = '0;
        if (bus.if_id_valid) begin
            ctrl.opcode       = ir[15:12];
            ctrl.aluop        = oh[AND] ? 3'd1 : oh[NOT] ? 3'd2 : oh[LEA] ? 3'd3 :
                                oh[SHF] ? (ir[4] ? (ir[5] ? 3'd6 : 3'd5) : 3'd4) : 3'd0;
            ctrl.load_regfile = writes;
            ctrl.load_cc      = oh[ADD] | oh[AND] | oh[NOT] | oh[SHF] | is_load;
            ctrl.mem_read     = is_load;
            ctrl.mem_write    = is_st;
            ctrl.mem_byte     = oh[LDB] | oh[STB];
            ctrl.indirect     = oh[LDI] | oh[STI];
            ctrl.is_br        = oh[BR];
            ctrl.is_jmp       = oh[JMP];
            ctrl.is_jsr       = oh[JSR];
            ctrl.is_trap      = oh[TRAP];
            ctrl.use_imm      = (oh[ADD] | oh[AND]) & ir[5];
            ctrl.dest         = dest;
            ctrl.sr1          = sr1;
            ctrl.sr2          = sr2;
            ctrl.sr1_used     = sr1_used;
            ctrl.sr2_used     = sr2_used;
            ctrl.cc_used      = oh[BR];
        end
    end

    // A single in-flight load that is retiring this cycle is not a hazard:
    // its data reaches the consumer through the write-through read path.
    assign dec_ld = bus.wb_is_load & bus.wb_regfile_we;
    assign haz_a  = sr1_used && cnt[sr1] != 2'd0 && !(cnt[sr1] == 2'd1 && dec_ld && bus.wb_dest == sr1);
    assign haz_b  = sr2_used && cnt[sr2] != 2'd0 && !(cnt[sr2] == 2'd1 && dec_ld && bus.wb_dest == sr2);
    assign haz_cc = oh[BR] && cc_cnt != 2'd0 && !(cc_cnt == 2'd1 && bus.wb_is_load && bus.wb_cc_we);
    assign stall  = bus.if_id_valid & (haz_a | haz_b | haz_cc);
    assign inc_ld = bus.if_id_valid & ~stall & ~bus.flush & ~bus.mem_stall & is_load;

    assign wb_nzp = {bus.wb_data[15], bus.wb_data == 16'd0, !bus.wb_data[15] && bus.wb_data != 16'd0};

    assign bus.pc_out      = bus.if_id_pc;
    assign bus.ir_out      = ir;
    assign bus.ctrl_out    = ctrl;
    assign bus.reg_a_out   = (bus.wb_regfile_we && bus.wb_dest == sr1) ? bus.wb_data : rf[sr1];
    assign bus.reg_b_out   = (bus.wb_regfile_we && bus.wb_dest == sr2) ? bus.wb_data : rf[sr2];
    assign bus.cc_out      = bus.wb_cc_we ? wb_nzp : cc;
    assign bus.if_id_load  = !bus.mem_stall && !stall;
    assign bus.id_ex_load  = !bus.mem_stall;
    assign bus.id_ex_clear = !bus.mem_stall && (stall || bus.flush || !bus.if_id_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf[i]  <= '0;
                cnt[i] <= '0;
            end
            cc     <= 3'b010;
            cc_cnt <= '0;
        end else begin
            if (bus.wb_regfile_we)
                rf[bus.wb_dest] <= bus.wb_data;
            if (bus.wb_cc_we)
                cc <= wb_nzp;
            for (int i = 0; i < 8; i++)
                cnt[i] <= cnt[i] + 2'(inc_ld && ir[11:9] == 3'(i)) - 2'(dec_ld && bus.wb_dest == 3'(i));
            cc_cnt <= cc_cnt + 2'(inc_ld) - 2'(dec_ld);
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed-vector bench for id_stage (interlock, bypass, CC, reset).
module tb_id_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    id_stage_if bus();
    id_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Scoreboard counters must never wrap.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(dut.inc_ld && (dut.cnt[bus.if_id_ir[11:9]] == 2'd3 || dut.cc_cnt == 2'd3)))
                else $error("scoreboard increment at 3");
            assert (!(dut.dec_ld && (dut.cnt[bus.wb_dest] == 2'd0 || dut.cc_cnt == 2'd0)))
                else $error("scoreboard decrement at 0");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [15:0] ir);
        bus.if_id_valid   = v;
        bus.if_id_ir      = ir;
        bus.if_id_pc      = 16'h3002;
        bus.flush         = 1'b0;
        bus.mem_stall     = 1'b0;
        bus.wb_regfile_we = 1'b0;
        bus.wb_dest       = 3'd0;
        bus.wb_data       = 16'h0000;
        bus.wb_cc_we      = 1'b0;
        bus.wb_is_load    = 1'b0;
    endtask

    task automatic wbw(input logic [2:0] d, input logic [15:0] data, input logic ld, input logic ccwe);
        bus.wb_regfile_we = 1'b1;
        bus.wb_dest       = d;
        bus.wb_data       = data;
        bus.wb_is_load    = ld;
        bus.wb_cc_we      = ccwe;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic ifl, input logic clr);
        check({tag, "_if_id_load"}, 32'(bus.if_id_load), 32'(ifl));
        check({tag, "_id_ex_clear"}, 32'(bus.id_ex_clear), 32'(clr));
    endtask

    initial begin
        fetch(1'b0, 16'h12C2);
        @(negedge clk);
        ctl("rst", 1'b1, 1'b1);
        check("rst_id_ex_load", 32'(bus.id_ex_load), 32'd1);
        check("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
        check("rst_cc", 32'(bus.cc_out), 32'b010);
        check("rst_reg_a", 32'(bus.reg_a_out), 32'h0);
        tick;
        reset = 1'b0;

        // ADD R1,R3,R2 while WB writes R3: write-through, then stored value
        fetch(1'b1, 16'h12C2);
        wbw(3'd3, 16'h1234, 1'b0, 1'b0);
        @(negedge clk);
        check("wt_reg_a", 32'(bus.reg_a_out), 32'h1234);
        check("wt_reg_b", 32'(bus.reg_b_out), 32'h0);
        check("add_ctrl", 32'(bus.ctrl_out), 32'h046002D6);
        check("pc_out", 32'(bus.pc_out), 32'h3002);
        check("ir_out", 32'(bus.ir_out), 32'h12C2);
        ctl("add", 1'b1, 1'b0);
        tick;
        fetch(1'b1, 16'h12C2);
        @(negedge clk);
        check("rf_reg_a", 32'(bus.reg_a_out), 32'h1234);
        tick;

        // CC write with bypass, then stored
        fetch(1'b0, 16'h12C2);
        wbw(3'd5, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        check("cc_bypass", 32'(bus.cc_out), 32'b100);
        check("inv_clear", 32'(bus.id_ex_clear), 32'd1);
        tick;
        fetch(1'b0, 16'h12C2);
        @(negedge clk);
        check("cc_stored", 32'(bus.cc_out), 32'b100);
        tick;

        // distance 1: LDR R2 ; ADD R4,R2,R2 -> two bubbles
        fetch(1'b1, 16'h6400);
        @(negedge clk);
        check("ldr_ctrl", 32'(bus.ctrl_out), 32'h18700404);
        ctl("d1_ldr", 1'b1, 1'b0);
        tick;
        for (int i = 0; i < 2; i++) begin
            fetch(1'b1, 16'h1882);
            @(negedge clk);
            ctl("d1_bubble", 1'b0, 1'b1);
            tick;
        end
        fetch(1'b1, 16'h1882);
        wbw(3'd2, 16'hBEEF, 1'b1, 1'b1);
        @(negedge clk);
        ctl("d1_issue", 1'b1, 1'b0);
        check("d1_reg_a", 32'(bus.reg_a_out), 32'hBEEF);
        check("d1_reg_b", 32'(bus.reg_b_out), 32'hBEEF);
        tick;

        // distance 2: LDR R2 ; NOT R5 ; ADD R4,R2,R0 -> one bubble
        fetch(1'b1, 16'h6400);
        tick;
        fetch(1'b1, 16'h9BBF);
        @(negedge clk);
        check("d2_not_if_id_load", 32'(bus.if_id_load), 32'd1);
        tick;
        fetch(1'b1, 16'h1880);
        @(negedge clk);
        ctl("d2_bubble", 1'b0, 1'b1);
        tick;
        fetch(1'b1, 16'h1880);
        wbw(3'd2, 16'h0042, 1'b1, 1'b1);
        @(negedge clk);
        ctl("d2_issue", 1'b1, 1'b0);
        check("d2_reg_a", 32'(bus.reg_a_out), 32'h0042);
        tick;

        // distance 3: no bubble
        fetch(1'b1, 16'h6400);
        tick;
        fetch(1'b1, 16'h9BBF);
        tick;
        fetch(1'b1, 16'h1DE1);
        @(negedge clk);
        check("d3_mid_if_id_load", 32'(bus.if_id_load), 32'd1);
        tick;
        fetch(1'b1, 16'h1880);
        wbw(3'd2, 16'h7000, 1'b1, 1'b1);
        @(negedge clk);
        ctl("d3_issue", 1'b1, 1'b0);
        check("d3_reg_a", 32'(bus.reg_a_out), 32'h7000);
        tick;

        // two loads to R2 in flight
        fetch(1'b1, 16'h6400);
        tick;
        fetch(1'b1, 16'h6400);
        @(negedge clk);
        check("ll_second_issue", 32'(bus.if_id_load), 32'd1);
        tick;
        fetch(1'b1, 16'h1880);
        @(negedge clk);
        check("ll_cnt2", 32'(dut.cnt[2]), 32'd2);
        check("ll_stall_mem", 32'(bus.if_id_load), 32'd0);
        tick;
        fetch(1'b1, 16'h1880);
        wbw(3'd2, 16'h1111, 1'b1, 1'b1);
        @(negedge clk);
        ctl("ll_first_wb", 1'b0, 1'b1);
        tick;
        fetch(1'b1, 16'h1880);
        wbw(3'd2, 16'h2222, 1'b1, 1'b1);
        @(negedge clk);
        ctl("ll_second_wb", 1'b1, 1'b0);
        check("ll_reg_a", 32'(bus.reg_a_out), 32'h2222);
        tick;

        // BRz waits for the load's CC
        fetch(1'b1, 16'h6400);
        tick;
        for (int i = 0; i < 2; i++) begin
            fetch(1'b1, 16'h0400);
            @(negedge clk);
            ctl("br_stall", 1'b0, 1'b1);
            check("br_cc_old", 32'(bus.cc_out), 32'b001);
            tick;
        end
        fetch(1'b1, 16'h0400);
        wbw(3'd2, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        ctl("br_issue", 1'b1, 1'b0);
        check("br_cc_bypass", 32'(bus.cc_out), 32'b010);
        tick;

        // flushed load never reaches the scoreboard
        fetch(1'b1, 16'h6400);
        bus.flush = 1'b1;
        @(negedge clk);
        ctl("flush", 1'b1, 1'b1);
        tick;
        fetch(1'b1, 16'h1880);
        @(negedge clk);
        ctl("post_flush", 1'b1, 1'b0);
        tick;

        // mem_stall during an interlock, then reset mid-stall
        fetch(1'b1, 16'h6400);
        wbw(3'd3, 16'h5555, 1'b0, 1'b1);
        tick;
        fetch(1'b1, 16'h1880);
        @(negedge clk);
        ctl("ms_pre", 1'b0, 1'b1);
        tick;
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, 16'h1880);
            bus.mem_stall = 1'b1;
            @(negedge clk);
            ctl("ms_frozen", 1'b0, 1'b0);
            check("ms_id_ex_load", 32'(bus.id_ex_load), 32'd0);
            check("ms_cnt", 32'(dut.cnt[2]), 32'd1);
            tick;
        end
        fetch(1'b1, 16'h1880);
        bus.mem_stall = 1'b1;
        #1;
        fetch(1'b0, 16'h12C2);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_cnt", 32'(dut.cnt[2]), 32'd0);
        check("mrst_cc_cnt", 32'(dut.cc_cnt), 32'd0);
        ctl("mrst", 1'b1, 1'b1);
        check("mrst_cc", 32'(bus.cc_out), 32'b010);
        check("mrst_reg_a", 32'(bus.reg_a_out), 32'h0);
        check("mrst_ctrl", 32'(bus.ctrl_out), 32'd0);
        tick;
        reset = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
